// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial add/subtract controller. One 1-bit full-adder cell is reused
//   for WIDTH cycles, one bit per cycle, LSB first. The block owns operand
//   capture, carry sequencing, the bit counter, result assembly and the
//   start/busy/done handshake.
//
//   Ports
//     clk    in   system clock, all state on rising edge
//     rst_n  in   synchronous active-low reset
//     start  in   begin an operation (sampled only in IDLE or DONE)
//     sub    in   0 = a + b + cin, 1 = a - b
//     a, b   in   WIDTH-bit operands, captured with start
//     cin    in   carry-in for add, ignored for subtract
//     busy   out  high for the WIDTH cycles of an operation
//     done   out  one-cycle pulse after the result is written
//     sum    out  registered result
//     cout   out  registered final carry (for subtract: 1 = no borrow)
//     ovf    out  registered two's-complement overflow

// Shared 1-bit full-adder cell, purely combinational.
module serial_add_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int             CW   = $clog2(WIDTH);
  localparam int             PW   = WIDTH - 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Operand request as seen by the serial datapath. Subtraction is folded
  // into the capture: b is inverted and the carry seeded with 1, so the
  // RUN loop only ever adds.
  typedef struct packed {
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
  } req_t;

  state_t        state, nxt;
  req_t          req;
  logic [CW-1:0] cnt;
  // Partial result holds the lower WIDTH-1 bits; the MSB is produced on the
  // completion edge and concatenated straight into sum.
  logic [PW-1:0] part;

  logic accept, last;
  logic fa_s, fa_co;

  serial_add_fa u_fa (
    .x  (req.op_a[0]),
    .y  (req.op_b[0]),
    .ci (req.carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Next state and handshake outputs
  always_comb begin
    nxt    = state;
    busy   = 1'b0;
    done   = 1'b0;
    accept = 1'b0;
    last   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          nxt    = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) begin
          last = 1'b1;
          nxt  = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        // Back-to-back: a start seen in the done cycle is taken directly.
        if (start) begin
          accept = 1'b1;
          nxt    = RUN;
        end else begin
          nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Datapath: operand shift registers, carry, counter, result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req  <= '0;
      cnt  <= '0;
      part <= '0;
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (accept) begin
      req.op_a  <= a;
      req.op_b  <= sub ? ~b : b;
      req.carry <= sub ? 1'b1 : cin;
      cnt       <= '0;
    end else if (state == RUN) begin
      req.op_a  <= req.op_a >> 1;
      req.op_b  <= req.op_b >> 1;
      req.carry <= fa_co;
      part      <= PW'({fa_s, part} >> 1);
      cnt       <= cnt + CW'(1);
      if (last) begin
        sum  <= {fa_s, part};
        cout <= fa_co;
        // On the MSB step the carry register is the carry into the MSB.
        ovf  <= req.carry ^ fa_co;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout, ovf;

  int total = 0;
  int bad   = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, returns {ovf, cout, sum}.
  function automatic logic [W+1:0] ref_op(input logic s, input logic [W-1:0] x,
                                          input logic [W-1:0] y, input logic ci);
    int ux, uy, sx, sy, ur, sr;
    logic [W-1:0] r;
    logic c, o;
    ux = int'(x);
    uy = int'(y);
    sx = x[W-1] ? ux - (1 << W) : ux;
    sy = y[W-1] ? uy - (1 << W) : uy;
    if (!s) begin
      ur = ux + uy + int'(ci);
      sr = sx + sy + int'(ci);
      c  = (ur >= (1 << W));
    end else begin
      ur = ux - uy;
      sr = sx - sy;
      c  = (ux >= uy);
    end
    r = W'(ur);
    o = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
    return {o, c, r};
  endfunction

  // One isolated operation; poke >= 0 pulses start with other operands in
  // that RUN cycle index (must be ignored).
  task automatic run_op(input string nm, input logic s, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic ci, input int poke,
                        input logic [W-1:0] e_sum, input logic e_cout, input logic e_ovf);
    @(negedge clk);
    start = 1'b1; sub = s; a = x; b = y; cin = ci;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      chk({nm, "_busy"}, busy, 1);
      chk({nm, "_done_early"}, done, 0);
      if (i == poke) begin
        start = 1'b1; sub = ~s; a = ~x; b = x; cin = ~ci;
      end else begin
        start = 1'b0; a = W'($urandom); b = W'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({nm, "_done"}, done, 1);
    chk({nm, "_busy_end"}, busy, 0);
    chk({nm, "_sum"}, sum, e_sum);
    chk({nm, "_cout"}, cout, e_cout);
    chk({nm, "_ovf"}, ovf, e_ovf);
    @(negedge clk);
    chk({nm, "_done_once"}, done, 0);
    chk({nm, "_idle"}, busy, 0);
  endtask

  typedef struct {
    logic         s;
    logic [W-1:0] x, y;
    logic         ci;
  } op_t;

  initial begin
    op_t q[$];
    op_t o, e;
    logic [W+1:0] r;
    int cyc, last_cyc, ndone;

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;

    run_op("add5a3c", 1'b0, 8'h5A, 8'h3C, 1'b0, -1, 8'h96, 1'b0, 1'b1);
    run_op("addff01", 1'b0, 8'hFF, 8'h01, 1'b0, -1, 8'h00, 1'b1, 1'b0);
    run_op("addcin",  1'b0, 8'h00, 8'h00, 1'b1, -1, 8'h01, 1'b0, 1'b0);
    run_op("sub1020", 1'b1, 8'h10, 8'h20, 1'b0, -1, 8'hF0, 1'b0, 1'b0);
    run_op("sub8001", 1'b1, 8'h80, 8'h01, 1'b1, -1, 8'h7F, 1'b1, 1'b1);
    run_op("ignore",  1'b0, 8'h12, 8'h34, 1'b0, 2,  8'h46, 1'b0, 1'b0);

    // Reset during RUN cycle 4: abandoned, results cleared, no done.
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 8'h77; b = 8'h11; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;  // reset wins over start
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_sum", sum, 0);
    chk("mrst_cout", cout, 0);
    chk("mrst_ovf", ovf, 0);
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      chk("mrst_nodone", done, 0);
      chk("mrst_nobusy", busy, 0);
    end
    run_op("postrst", 1'b1, 8'h05, 8'h07, 1'b0, -1, 8'hFE, 1'b0, 1'b0);

    // Back-to-back randomized run with start held high.
    @(negedge clk);
    o.s = 1'($urandom); o.x = W'($urandom); o.y = W'($urandom); o.ci = 1'($urandom);
    start = 1'b1; sub = o.s; a = o.x; b = o.y; cin = o.ci;
    q.push_back(o);
    cyc = 0; last_cyc = 0; ndone = 0;
    while (ndone < 1000 && cyc < 1001 * (W + 1) + 50) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        e = q.pop_front();
        r = ref_op(e.s, e.x, e.y, e.ci);
        chk("b2b_sum", sum, r[W-1:0]);
        chk("b2b_cout", cout, r[W]);
        chk("b2b_ovf", ovf, r[W+1]);
        if (ndone > 0) chk("b2b_period", cyc - last_cyc, W + 1);
        last_cyc = cyc;
        ndone++;
        if (ndone < 1000) begin
          o.s = 1'($urandom); o.x = W'($urandom); o.y = W'($urandom); o.ci = 1'($urandom);
          sub = o.s; a = o.x; b = o.y; cin = o.ci;
          q.push_back(o);
        end else begin
          start = 1'b0;
        end
      end else begin
        chk("b2b_busy", busy, 1);
        sub = 1'($urandom); a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end
    end
    chk("b2b_count", ndone, 1000);
    start = 1'b0;
    @(negedge clk);
    chk("b2b_final_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
